// File: rtl/data_in_seq_pkg.sv
// Shared constants and state encoding for the layer input slicer sequencer.
package data_in_seq_pkg;

  localparam int unsigned BIT_LENGTH = 16;
  localparam int unsigned DATA_N     = 6;
  localparam int unsigned N_SLICE    = 4;
  localparam int unsigned FRAME_LEN  = 102;
  localparam int unsigned DRAIN_LEN  = 8;
  localparam int unsigned N_LAYER    = 3;

  // One output slice: DATA_N lanes of BIT_LENGTH bits
  localparam int unsigned W = BIT_LENGTH * DATA_N;

  localparam int unsigned SEL_W   = $clog2(N_SLICE);
  localparam int unsigned BEAT_W  = $clog2(FRAME_LEN);
  localparam int unsigned LAYER_W = $clog2(N_LAYER);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/data_slice_mux.sv
// Combinational N_SLICE:1 slice selector; an out-of-range select yields zero.
module data_slice_mux
  import data_in_seq_pkg::*;
#(
  parameter int unsigned SLICE_W = W,
  parameter int unsigned NS      = N_SLICE,
  parameter int unsigned SW      = $clog2(NS)
) (
  input  logic [NS*SLICE_W-1:0] data_i,
  input  logic [SW-1:0]         sel_i,
  output logic [SLICE_W-1:0]    slice_o
);

  // Pick slice sel_i; default zero covers unused select codes
  always_comb begin
    slice_o = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (sel_i == SW'(k)) slice_o = data_i[k*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/data_in_seq.sv
// Layer input slicer sequencer: splits 4-slice words into one slice per beat,
// runs N_LAYER frames of FRAME_LEN beats separated by DRAIN_LEN flush gaps.
module data_in_seq
  import data_in_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_SLICE*W-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  output logic [BEAT_W-1:0]      beat_idx,
  output logic [LAYER_W-1:0]     layer_idx,
  output logic                   busy,
  output logic                   done
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]    beat_idx_q, beat_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W-1:0]         slice;
  logic                 last_beat;
  logic                 last_sel;

  data_slice_mux #(
    .SLICE_W (W),
    .NS      (N_SLICE),
    .SW      (SEL_W)
  ) u_mux (
    .data_i  (in_data),
    .sel_i   (sel_q),
    .slice_o (slice)
  );

  assign last_beat = (beat_q == BEAT_W'(FRAME_LEN - 1));
  assign last_sel  = (sel_q == SEL_W'(N_SLICE - 1));

  // Next-state, counter and output-register decode
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    layer_d     = layer_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    beat_idx_d  = beat_idx_q;
    in_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sel_d   = '0;
          beat_d  = '0;
          layer_d = '0;
        end
      end
      ST_RUN: begin
        // Only the first slice of a word waits on in_valid; later slices
        // come from the word already held stable by the source.
        if (!((sel_q == '0) && !in_valid)) begin
          out_data_d  = slice;
          out_valid_d = 1'b1;
          beat_idx_d  = beat_q;
          in_ready    = last_sel || last_beat;
          if (last_beat) begin
            state_d = ST_DRAIN;
            sel_d   = '0;
            beat_d  = '0;
            drain_d = '0;
          end else begin
            sel_d  = last_sel ? '0 : sel_q + SEL_W'(1);
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) begin
          drain_d = '0;
          if (layer_q == LAYER_W'(N_LAYER - 1)) begin
            state_d = ST_DONE;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = ST_RUN;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort (and reset) override every other event, including consumption
    if (rst || abort) begin
      state_d     = ST_IDLE;
      sel_d       = '0;
      beat_d      = '0;
      drain_d     = '0;
      layer_d     = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      beat_idx_d  = '0;
      in_ready    = 1'b0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      layer_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      beat_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      layer_q     <= layer_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      beat_idx_q  <= beat_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign beat_idx  = beat_idx_q;
  assign layer_idx = layer_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_data_in_seq.sv
// Directed self-checking bench for data_in_seq.
module tb_data_in_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [383:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  out_data;
  logic         out_valid;
  logic [6:0]   beat_idx;
  logic [1:0]   layer_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int unsigned wseq = 0;

  always #5 clk = ~clk;

  data_in_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .beat_idx  (beat_idx),
    .layer_idx (layer_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane value of slice k of word ws: word number in the top bits, k+1 in the low nibble
  function automatic logic [95:0] exp_slice(input int unsigned ws, input int unsigned k);
    logic [95:0] r;
    logic [31:0] w32;
    w32 = ws;
    for (int lane = 0; lane < 6; lane++) r[lane*16 +: 16] = {w32[11:0], 4'(k + 1)};
    return r;
  endfunction

  function automatic logic [383:0] mk_word(input int unsigned ws);
    logic [383:0] r;
    for (int unsigned k = 0; k < 4; k++) r[k*96 +: 96] = exp_slice(ws, k);
    return r;
  endfunction

  // One start-to-finish run; optional stall (layer, beat 40), abort (layer, beat 50),
  // and extra start pulses during RUN and DONE.
  task automatic run_seq(input int stall_layer, input int abort_layer, input bit poke);
    int exp_beat = 0;
    int exp_layer = 0;
    int zrun = 0;
    int rdy_cnt = 0;
    int stall_left = 5;
    int done_cnt = 0;
    int post = 0;
    int cyc = 0;
    int unsigned emit_w;
    bit first = 1'b1;
    bit finished = 1'b0;
    bit last_rdy;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      start = (cyc == 0) || (poke && (done || (exp_layer == 0 && exp_beat == 30)));
      in_valid = 1'b1;
      if (exp_layer == stall_layer && exp_beat == 40 && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end
      abort = (exp_layer == abort_layer && exp_beat == 50);
      in_data = mk_word(wseq);
      #1;
      emit_w = wseq;
      last_rdy = in_ready;
      if (in_ready) begin
        rdy_cnt++;
        wseq++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (abort) begin
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_layer", layer_idx, 0);
        check_eq("abort_beat", beat_idx, 0);
        check_eq("abort_data", out_data, 0);
        check_eq("abort_busy", busy, 0);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b1;
        #1;
        check_eq("abort_rdy", in_ready, 0);
        finished = 1'b1;
      end else if (out_valid) begin
        if (first) check_eq("start_lat", zrun, 1);
        else if (zrun > 0 && exp_beat == 0) check_eq("drain_gap", zrun, 8);
        else if (zrun > 0) check_eq("stall_gap", zrun, 5);
        first = 1'b0;
        zrun = 0;
        check_eq("beat_idx", beat_idx, exp_beat);
        check_eq("layer_idx", layer_idx, exp_layer);
        check_eq("out_data", out_data, exp_slice(emit_w, exp_beat % 4));
        check_eq("busy_run", busy, 1);
        if (exp_beat == 101) begin
          check_eq("rdy_end", last_rdy, 1);
          check_eq("rdy_per_frame", rdy_cnt, 26);
          rdy_cnt = 0;
          exp_beat = 0;
          exp_layer++;
        end else begin
          exp_beat++;
        end
      end else begin
        zrun++;
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_done", busy, 0);
      end else if (done_cnt > 0) begin
        post++;
        check_eq("busy_post", busy, 0);
        check_eq("valid_post", out_valid, 0);
        if (post == 4) begin
          check_eq("done_cnt", done_cnt, 1);
          check_eq("frames", exp_layer, 3);
          finished = 1'b1;
        end
      end
    end
    if (!finished) check_eq("timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    in_valid = 1'b1;
    in_data = mk_word(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_beat", beat_idx, 0);
    check_eq("rst_layer", layer_idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rdy", in_ready, 0);
    rst = 1'b0;
    start = 1'b0;
    #1;
    check_eq("idle_rdy", in_ready, 0);

    run_seq(-1, -1, 1'b0);
    run_seq(0, -1, 1'b1);
    run_seq(-1, 1, 1'b0);
    run_seq(-1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
